// File: rtl/instruction_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit_if
// Bundles the fetch stage's control, loader and IF/ID signals.
//   Control : i_start, i_program, i_stall, i_flush, i_halt, i_jump, i_jump_address
//   Loader  : i_load_valid, i_load_addr, i_load_data -> o_load_ready
//   IF/ID   : o_instruction, o_pc, o_pc_plus4, o_valid
//   Status  : o_halted, o_fault
// Modports: master = pipeline/debug side that drives the requests,
//           slave  = the fetch unit itself.
// -----------------------------------------------------------------------------
interface instruction_fetch_unit_if #(
    parameter int INST_WIDTH = 32
);
    logic                  i_start;
    logic                  i_program;
    logic                  i_stall;
    logic                  i_flush;
    logic                  i_halt;
    logic                  i_jump;
    logic [31:0]           i_jump_address;
    logic                  i_load_valid;
    logic [31:0]           i_load_addr;
    logic [INST_WIDTH-1:0] i_load_data;
    logic                  o_load_ready;
    logic [INST_WIDTH-1:0] o_instruction;
    logic [31:0]           o_pc;
    logic [31:0]           o_pc_plus4;
    logic                  o_valid;
    logic                  o_halted;
    logic                  o_fault;

    modport master (
        output i_start, i_program, i_stall, i_flush, i_halt, i_jump, i_jump_address,
        output i_load_valid, i_load_addr, i_load_data,
        input  o_load_ready, o_instruction, o_pc, o_pc_plus4, o_valid, o_halted, o_fault
    );

    modport slave (
        input  i_start, i_program, i_stall, i_flush, i_halt, i_jump, i_jump_address,
        input  i_load_valid, i_load_addr, i_load_data,
        output o_load_ready, o_instruction, o_pc, o_pc_plus4, o_valid, o_halted, o_fault
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
// IF stage of the pipelined MIPS core. Owns a byte-addressable instruction
// memory (combinational read, synchronous write from the debug loader), the
// program counter and the IF/ID pipeline latch.
// Ports:
//   i_clk   : clock, everything updates on the rising edge
//   i_reset : synchronous, active-high reset (returns to LOAD, PC = RESET_PC)
//   bus     : instruction_fetch_unit_if.slave (control, loader, IF/ID, status)
// States: LOAD (loader may write memory), RUN (fetching), HALTED (frozen).
// -----------------------------------------------------------------------------
module instruction_fetch_unit #(
    parameter int                    INST_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 10,
    parameter logic [31:0]           RESET_PC   = 32'h0000_0000,
    parameter logic [INST_WIDTH-1:0] NOP_INST   = {INST_WIDTH{1'b0}}
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    instruction_fetch_unit_if.slave  bus
);
    localparam int          W         = INST_WIDTH / 8;
    localparam int          MEM_BYTES = 1 << ADDR_WIDTH;
    localparam logic [31:0] PC_STEP   = 32'(W);

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [31:0]             pc_q, pc_d;
    logic [INST_WIDTH-1:0]   instr_q, instr_d;
    logic [31:0]             ifid_pc_q, ifid_pc_d;
    logic [31:0]             ifid_pc4_q, ifid_pc4_d;
    logic                    valid_q, valid_d;
    logic                    fault_q, fault_d;
    logic                    halted_q;
    logic                    load_ready_q;

    logic [7:0]              mem_q [MEM_BYTES];
    logic [INST_WIDTH-1:0]   fetch_word_s;
    logic [ADDR_WIDTH-1:0]   load_base_s;
    logic                    load_we_s;
    logic [31:0]             jump_target_s;
    logic                    jump_misaligned_s;
    logic [31:0]             pc_next_s;
    logic                    unused_load_addr_s;

    // Loader word base: the two low address bits are ignored.
    assign load_base_s = {bus.i_load_addr[ADDR_WIDTH-1:2], 2'b00};
    // Reset wins over a write presented in the same cycle.
    assign load_we_s   = !i_reset && (state_q == ST_LOAD) && bus.i_load_valid;
    assign unused_load_addr_s = ^{bus.i_load_addr[31:ADDR_WIDTH], bus.i_load_addr[1:0]};

    assign jump_target_s     = {bus.i_jump_address[31:2], 2'b00};
    assign jump_misaligned_s = |bus.i_jump_address[1:0];
    assign pc_next_s         = bus.i_jump ? jump_target_s : (pc_q + PC_STEP);

    // Instruction memory write port; byte addresses wrap at the top of memory.
    always_ff @(posedge i_clk) begin
        if (load_we_s) begin
            for (int k = 0; k < W; k++) begin
                mem_q[load_base_s + ADDR_WIDTH'(k)] <= bus.i_load_data[8*k +: 8];
            end
        end
    end

    // Little-endian combinational word read at the current PC.
    always_comb begin
        fetch_word_s = NOP_INST;
        for (int k = 0; k < W; k++) begin
            fetch_word_s[8*k +: 8] = mem_q[pc_q[ADDR_WIDTH-1:0] + ADDR_WIDTH'(k)];
        end
    end

    // Next-state and IF/ID update logic.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        ifid_pc_d  = ifid_pc_q;
        ifid_pc4_d = ifid_pc4_q;
        valid_d    = valid_q;
        fault_d    = fault_q;

        case (state_q)
            ST_LOAD: begin
                instr_d = NOP_INST;
                valid_d = 1'b0;
                if (bus.i_start) begin
                    state_d = ST_RUN;
                    pc_d    = RESET_PC;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_RUN: begin
                if (bus.i_program) begin
                    // PC is kept until the next start.
                    state_d = ST_LOAD;
                    instr_d = NOP_INST;
                    valid_d = 1'b0;
                end else if (bus.i_halt) begin
                    state_d = ST_HALTED;
                end else if (bus.i_flush) begin
                    // Flush beats stall: bubble into IF/ID, PC still advances.
                    instr_d = NOP_INST;
                    valid_d = 1'b0;
                    pc_d    = pc_next_s;
                    fault_d = fault_q | (bus.i_jump & jump_misaligned_s);
                end else if (bus.i_stall) begin
                    // A jump under stall is dropped; the hazard unit re-presents it.
                    pc_d = pc_q;
                end else begin
                    instr_d    = fetch_word_s;
                    ifid_pc_d  = pc_q;
                    ifid_pc4_d = pc_q + PC_STEP;
                    valid_d    = 1'b1;
                    pc_d       = pc_next_s;
                    fault_d    = fault_q | (bus.i_jump & jump_misaligned_s);
                end
            end
            ST_HALTED: begin
                if (bus.i_program) begin
                    state_d = ST_LOAD;
                    instr_d = NOP_INST;
                    valid_d = 1'b0;
                end else begin
                    state_d = ST_HALTED;
                end
            end
            default: begin
                state_d = ST_LOAD;
                instr_d = NOP_INST;
                valid_d = 1'b0;
            end
        endcase
    end

    // State, PC, IF/ID latch and status flags.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= ST_LOAD;
            pc_q         <= RESET_PC;
            instr_q      <= NOP_INST;
            ifid_pc_q    <= 32'h0000_0000;
            ifid_pc4_q   <= 32'h0000_0000;
            valid_q      <= 1'b0;
            fault_q      <= 1'b0;
            halted_q     <= 1'b0;
            load_ready_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_pc4_q   <= ifid_pc4_d;
            valid_q      <= valid_d;
            fault_q      <= fault_d;
            halted_q     <= (state_d == ST_HALTED);
            load_ready_q <= (state_d == ST_LOAD);
        end
    end

    assign bus.o_load_ready  = load_ready_q;
    assign bus.o_instruction = instr_q;
    assign bus.o_pc          = ifid_pc_q;
    assign bus.o_pc_plus4    = ifid_pc4_q;
    assign bus.o_valid       = valid_q;
    assign bus.o_halted      = halted_q;
    assign bus.o_fault       = fault_q;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch_unit
// Scoreboard bench: each driven cycle updates a behavioural model of the fetch
// stage, pushes the expected post-edge outputs and pops/compares them after
// the rising edge. A few fixed program values are also checked directly.
// -----------------------------------------------------------------------------
module tb_instruction_fetch_unit;
    localparam int IW = 32;
    localparam int AW = 8;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        valid;
        logic        halted;
        logic        ready;
        logic        fault;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instruction_fetch_unit_if #(.INST_WIDTH(IW)) bus ();

    instruction_fetch_unit #(.INST_WIDTH(IW), .ADDR_WIDTH(AW)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    // Reference model state (0 = LOAD, 1 = RUN, 2 = HALTED)
    int          m_state;
    logic [31:0] m_pc, m_instr, m_ifpc, m_ifpc4;
    logic        m_valid, m_fault;
    logic [7:0]  m_mem [256];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [7:0] b;
        b = a[7:0];
        return {m_mem[b + 8'd3], m_mem[b + 8'd2], m_mem[b + 8'd1], m_mem[b]};
    endfunction

    task automatic model_update();
        logic [31:0] tgt, nxt;
        logic [7:0]  base;
        tgt = {bus.i_jump_address[31:2], 2'b00};
        nxt = bus.i_jump ? tgt : (m_pc + 32'd4);
        if (rst) begin
            m_state = 0; m_pc = 32'd0; m_instr = 32'd0; m_ifpc = 32'd0;
            m_ifpc4 = 32'd0; m_valid = 1'b0; m_fault = 1'b0;
        end else if (m_state == 0) begin
            if (bus.i_load_valid) begin
                base = bus.i_load_addr[7:0] & 8'hFC;
                for (int k = 0; k < 4; k++) m_mem[base + 8'(k)] = bus.i_load_data[8*k +: 8];
            end
            if (bus.i_start) begin
                m_state = 1; m_pc = 32'd0;
            end
        end else if (m_state == 1) begin
            if (bus.i_program) begin
                m_state = 0; m_instr = 32'd0; m_valid = 1'b0;
            end else if (bus.i_halt) begin
                m_state = 2;
            end else if (bus.i_flush) begin
                m_instr = 32'd0; m_valid = 1'b0; m_pc = nxt;
                if (bus.i_jump && bus.i_jump_address[1:0] != 2'b00) m_fault = 1'b1;
            end else if (!bus.i_stall) begin
                m_instr = m_read(m_pc); m_ifpc = m_pc; m_ifpc4 = m_pc + 32'd4;
                m_valid = 1'b1; m_pc = nxt;
                if (bus.i_jump && bus.i_jump_address[1:0] != 2'b00) m_fault = 1'b1;
            end
        end else begin
            if (bus.i_program) begin
                m_state = 0; m_instr = 32'd0; m_valid = 1'b0;
            end
        end
    endtask

    task automatic idle_inputs();
        bus.i_start = 1'b0; bus.i_program = 1'b0; bus.i_stall = 1'b0;
        bus.i_flush = 1'b0; bus.i_halt = 1'b0; bus.i_jump = 1'b0;
        bus.i_jump_address = 32'd0; bus.i_load_valid = 1'b0;
        bus.i_load_addr = 32'd0; bus.i_load_data = 32'd0;
    endtask

    // One clock: model + push, edge, pop + compare, then return inputs to idle.
    task automatic step();
        exp_t e, g;
        model_update();
        e = '{instr: m_instr, pc: m_ifpc, pc4: m_ifpc4, valid: m_valid,
              halted: (m_state == 2), ready: (m_state == 0), fault: m_fault};
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        g = exp_q.pop_front();
        check_eq("instruction", 64'(bus.o_instruction), 64'(g.instr));
        check_eq("pc",          64'(bus.o_pc),          64'(g.pc));
        check_eq("pc_plus4",    64'(bus.o_pc_plus4),    64'(g.pc4));
        check_eq("valid",       64'(bus.o_valid),       64'(g.valid));
        check_eq("halted",      64'(bus.o_halted),      64'(g.halted));
        check_eq("load_ready",  64'(bus.o_load_ready),  64'(g.ready));
        check_eq("fault",       64'(bus.o_fault),       64'(g.fault));
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic load_word(input logic [31:0] a, input logic [31:0] d);
        bus.i_load_valid = 1'b1; bus.i_load_addr = a; bus.i_load_data = d;
        step();
    endtask

    task automatic flush_jump(input logic [31:0] a);
        bus.i_flush = 1'b1; bus.i_jump = 1'b1; bus.i_jump_address = a;
        step();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        step();
        step();
        rst = 1'b0;

        // Program image (0x43 exercises ignored low address bits -> 0x40)
        load_word(32'h0000_0000, 32'h1111_1111);
        load_word(32'h0000_0004, 32'h2222_2222);
        load_word(32'h0000_0008, 32'h3333_3333);
        load_word(32'h0000_000C, 32'h4444_4444);
        load_word(32'h0000_0014, 32'h6666_6666);
        load_word(32'h0000_0043, 32'h5555_5555);
        load_word(32'h0000_00FC, 32'hDEAD_BEEF);
        bus.i_start = 1'b1;
        step();

        step();
        check_eq("first_fetch", 64'(bus.o_instruction), 64'h1111_1111);
        step();
        // Stall at PC=8; a jump under stall must be ignored
        bus.i_stall = 1'b1; bus.i_jump = 1'b1; bus.i_jump_address = 32'h0000_0080;
        step();
        bus.i_stall = 1'b1; step();
        bus.i_stall = 1'b1; step();
        step();
        check_eq("resume_pc", 64'(bus.o_pc), 64'h8);

        flush_jump(32'h0000_0040);
        step();
        check_eq("jump_fetch", 64'(bus.o_instruction), 64'h5555_5555);
        flush_jump(32'h0000_0042);
        step();
        // Flush together with stall: flush wins
        bus.i_stall = 1'b1;
        flush_jump(32'h0000_0008);
        step();

        // Halt at PC=0xC and hold for 10 cycles; loader writes are ignored
        bus.i_halt = 1'b1; step();
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                bus.i_load_valid = 1'b1; bus.i_load_addr = 32'h4; bus.i_load_data = 32'h9999_9999;
            end
            if (i == 5) begin
                bus.i_start = 1'b1; bus.i_flush = 1'b1; bus.i_jump = 1'b1;
                bus.i_jump_address = 32'h40;
            end
            step();
        end
        bus.i_program = 1'b1; step();
        load_word(32'h0000_0000, 32'hAAAA_AAAA);
        bus.i_start = 1'b1; step();
        step();
        check_eq("reload_fetch", 64'(bus.o_instruction), 64'hAAAA_AAAA);
        step();

        // Address wrap: 0x1FC reads byte address 0xFC
        flush_jump(32'h0000_01FC);
        step();
        check_eq("wrap_fetch", 64'(bus.o_instruction), 64'hDEAD_BEEF);
        step();
        // 32-bit PC wrap
        flush_jump(32'hFFFF_FFFC);
        step();
        check_eq("pc4_wrap", 64'(bus.o_pc_plus4), 64'h0);

        // Back to LOAD from RUN, reset mid-load; memory keeps earlier writes
        bus.i_program = 1'b1; step();
        load_word(32'h0000_0010, 32'h7777_7777);
        rst = 1'b1;
        bus.i_load_valid = 1'b1; bus.i_load_addr = 32'h14; bus.i_load_data = 32'hBAD0_BAD0;
        step();
        rst = 1'b0;
        bus.i_start = 1'b1; step();
        flush_jump(32'h0000_0010);
        step();
        check_eq("retained_0x10", 64'(bus.o_instruction), 64'h7777_7777);
        step();
        check_eq("retained_0x14", 64'(bus.o_instruction), 64'h6666_6666);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Parametrised IF stage for the pipelined MIPS core. It is the next generation of the fixed 32-bit/256-byte fetch stage.
- Owns a byte-addressable instruction memory with asynchronous read and synchronous write.
- Owns the program counter, with jump redirect, stall, flush and halt support.
- Includes a load mode in which the debug unit writes the program before execution.
- Drives the IF/ID latch: instruction, PC, PC+4 and valid.

Parameters:
INST_WIDTH, 32, instruction/word width in bits; must be a multiple of 8.
ADDR_WIDTH, 10, instruction memory byte-address width (2^ADDR_WIDTH bytes).
RESET_PC, 0, PC value loaded on reset and on every LOAD->RUN transition.
NOP_INST, 0, instruction injected into the IF/ID latch on flush or reset.

Ports:
i_clk  in  1  clock, all state updates on rising edge
i_reset  in  1  synchronous, active-high reset
i_start  in  1  pulse; leaves LOAD and begins execution
i_program  in  1  pulse; from RUN or HALTED, returns to LOAD
i_stall  in  1  hazard unit stall; freezes PC and IF/ID latch
i_flush  in  1  control hazard; injects NOP into IF/ID
i_halt  in  1  halt request; enters HALTED
i_jump  in  1  PC redirect valid
i_jump_address  in  32  redirect target (byte address)
i_load_valid  in  1  loader write strobe
i_load_addr  in  32  loader byte address
i_load_data  in  INST_WIDTH  loader word
o_load_ready  out  1  high only in LOAD state
o_instruction  out  INST_WIDTH  IF/ID instruction latch
o_pc  out  32  IF/ID latched PC of o_instruction
o_pc_plus4  out  32  IF/ID latched PC+INST_WIDTH/8
o_valid  out  1  IF/ID latch holds a real fetched instruction
o_halted  out  1  high in HALTED state
o_fault  out  1  sticky misaligned-jump flag

Behaviour:
- Reset: i_reset is synchronous, active-high, on clock i_clk. Reset has the highest priority and applies in any state, including mid-load.
  - Reset state is LOAD; internal PC = RESET_PC.
  - Outputs at reset: o_instruction = NOP_INST, o_pc = 0, o_pc_plus4 = 0, o_valid = 0, o_fault = 0, o_halted = 0.
  - Memory contents are not cleared by reset.
- Memory:
  - W = INST_WIDTH/8 bytes per word.
  - Read word at address a = {mem[a+W-1], ..., mem[a]} (little-endian); read is combinational.
  - All byte addresses are taken modulo 2^ADDR_WIDTH, so a word read/write at the top of memory wraps to byte 0.
- States: LOAD, RUN, HALTED.
- LOAD:
  - o_load_ready = 1. A write occurs on each cycle where i_load_valid = 1, storing W bytes at i_load_addr with bits [1:0] ignored, taking effect on the same edge.
  - PC is held; the IF/ID latch holds NOP_INST with o_valid = 0.
  - i_start -> RUN with PC = RESET_PC. If i_start and i_load_valid arrive in the same cycle, the write completes and the transition is also taken.
  - i_stall, i_flush, i_halt and i_jump are ignored.
- RUN, per rising edge, in priority order:
  1. i_halt -> HALTED; PC and IF/ID frozen at current values.
  2. i_flush -> IF/ID = NOP_INST with o_valid = 0. PC <= i_jump ? target : PC+W. Flush overrides stall.
  3. i_stall -> PC and IF/ID hold.
  4. Otherwise -> IF/ID captures mem[PC], PC, PC+W with o_valid = 1. PC <= i_jump ? target : PC+W.
- Fetch latency: the instruction at PC appears on o_instruction one cycle after PC is presented.
- Jump target:
  - Target = {i_jump_address[31:2], 2'b00}.
  - If i_jump_address[1:0] != 0, o_fault is set and stays set until reset.
  - A jump during stall (without flush) is ignored; the hazard unit must hold i_jump.
- PC arithmetic: 32-bit, wraps modulo 2^32. The memory index uses the low ADDR_WIDTH bits.
- i_program in RUN or HALTED -> LOAD. On that transition the IF/ID latch becomes NOP_INST with o_valid = 0, and PC is kept until i_start.
- HALTED:
  - o_halted = 1; all outputs hold.
  - Only i_program or i_reset exits.
  - i_load_valid is ignored outside LOAD.

Test Plan:
- Reset then load words 0x11111111@0, 0x22222222@4, 0x33333333@8; pulse i_start -> successive edges give o_instruction 0x11111111/0x22222222/0x33333333, o_pc 0/4/8, o_pc_plus4 4/8/12, o_valid = 1.
- In RUN at PC=8, assert i_stall for 3 cycles -> o_instruction and o_pc unchanged for 3 cycles; fetch then resumes at 8.
- Jump with i_jump_address=0x40 plus i_flush -> next IF/ID = NOP_INST with o_valid = 0; the following cycle fetches mem[0x40] with o_pc = 0x40. A jump to 0x42 sets o_fault and fetches from 0x40.
- Assert i_halt at PC=0xC -> o_halted = 1 and outputs frozen for 10 cycles. Pulse i_program -> o_load_ready = 1; rewrite @0 with 0xAAAAAAAA and pulse i_start -> first fetch returns 0xAAAAAAAA at o_pc = 0.
- ADDR_WIDTH=8, write 0xDEADBEEF at 0xFC then fetch at 0x1FC -> instruction 0xDEADBEEF via address wrap. Assert i_reset mid-load -> state LOAD, o_valid = 0, and memory retains earlier writes.
